// File: rtl/expr_collector_if.sv
// expr_collector_if
//   Character-in / expression-out bundle for the expression collector.
//   Character side:   char_valid, char_data[7:0] (to collector), char_ready (from collector)
//   Expression side:  p1, sym, p2 [7:0], expr_valid, err, expr_cnt[7:0] (from collector),
//                     expr_ready (to collector)
//   slave  modport: the collector itself.
//   master modport: whoever feeds characters and consumes expressions.
interface expr_collector_if;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;
    logic [7:0] p1;
    logic [7:0] p2;
    logic [7:0] sym;
    logic       expr_valid;
    logic       expr_ready;
    logic       err;
    logic [7:0] expr_cnt;

    modport slave (
        input  char_valid, char_data, expr_ready,
        output char_ready, p1, p2, sym, expr_valid, err, expr_cnt
    );

    modport master (
        output char_valid, char_data, expr_ready,
        input  char_ready, p1, p2, sym, expr_valid, err, expr_cnt
    );
endinterface

// File: rtl/expr_collector.sv
// expr_collector
//   Collects an ASCII "digit op digit =" sequence into a single-digit
//   expression (p1 sym p2) and hands it downstream on a valid/ready handshake.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - expr_collector_if.slave (character input, expression output,
//            err pulse, completed-handshake counter)
//   Build option:
//     EXPR_COLLECTOR_DIVZERO_CHECK_EN - when defined, "d / 0 =" is rejected
//     with err instead of being issued.
module expr_collector (
    input  logic              clk,
    input  logic              rst,
    expr_collector_if.slave   bus
);
    typedef enum logic [2:0] {S_D1, S_OP, S_D2, S_EQ, S_OUT} state_t;

    state_t     state, state_d;
    logic [7:0] p1_q, p1_d;
    logic [7:0] p2_q, p2_d;
    logic [7:0] sym_q, sym_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_d, err_q;

    logic [7:0] c;
    logic       is_digit, is_op, is_eq, is_clear, accept, div_zero;

    assign c        = bus.char_data;
    assign is_digit = (c >= 8'h30) && (c <= 8'h39);
    assign is_op    = (c == 8'h2b) || (c == 8'h2d) || (c == 8'h2a) || (c == 8'h2f);
    assign is_eq    = (c == 8'h3d);
    assign is_clear = (c == 8'h43) || (c == 8'h63);
    // Characters are only taken while no expression is waiting downstream.
    assign accept   = bus.char_valid && (state != S_OUT);

`ifdef EXPR_COLLECTOR_DIVZERO_CHECK_EN
    assign div_zero = (sym_q == 8'h2f) && (p2_q == 8'h30);
`else
    assign div_zero = 1'b0;
`endif

    always_comb begin
        state_d = state;
        p1_d    = p1_q;
        p2_d    = p2_q;
        sym_d   = sym_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        if (accept) begin
            if (is_clear) begin
                // Clear restarts collection but keeps the operand registers.
                state_d = S_D1;
            end else begin
                case (state)
                    S_D1: begin
                        if (is_digit) begin
                            p1_d    = c;
                            state_d = S_OP;
                        end else begin
                            err_d   = 1'b1;
                        end
                    end
                    S_OP: begin
                        if (is_op) begin
                            sym_d   = c;
                            state_d = S_D2;
                        end else if (is_digit) begin
                            p1_d    = c;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_D1;
                        end
                    end
                    S_D2: begin
                        if (is_digit) begin
                            p2_d    = c;
                            state_d = S_EQ;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_D1;
                        end
                    end
                    S_EQ: begin
                        if (is_eq && !div_zero) begin
                            state_d = S_OUT;
                        end else if (is_digit) begin
                            p2_d    = c;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_D1;
                        end
                    end
                    default: ;
                endcase
            end
        end
        if ((state == S_OUT) && bus.expr_ready) begin
            state_d = S_D1;
            cnt_d   = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_D1;
            p1_q  <= 8'h30;
            p2_q  <= 8'h30;
            sym_q <= 8'h2b;
            cnt_q <= 8'h00;
            err_q <= 1'b0;
        end else begin
            state <= state_d;
            p1_q  <= p1_d;
            p2_q  <= p2_d;
            sym_q <= sym_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.p1         = p1_q;
    assign bus.p2         = p2_q;
    assign bus.sym        = sym_q;
    assign bus.expr_cnt   = cnt_q;
    assign bus.err        = err_q;
    assign bus.expr_valid = (state == S_OUT);
    assign bus.char_ready = (state != S_OUT);
endmodule

// File: tb/tb_expr_collector.sv
// tb_expr_collector
//   Randomized + directed bench for expr_collector. A token-count reference
//   model predicts every output; a negedge process compares each cycle, and
//   directed sequences add hand-computed literal expectations.
module tb_expr_collector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    expr_collector_if bus();

    expr_collector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // tok = number of expression tokens collected so far (0..3),
    // pend = a finished expression is waiting for the consumer.
    int         m_tok  = 0;
    bit         m_pend = 1'b0;
    bit         m_err  = 1'b0;
    logic [7:0] m_p1 = 8'h30, m_p2 = 8'h30, m_sym = 8'h2b, m_cnt = 8'h00;

    function automatic bit f_digit(input logic [7:0] x);
        return x >= "0" && x <= "9";
    endfunction
    function automatic bit f_op(input logic [7:0] x);
        return x == "+" || x == "-" || x == "*" || x == "/";
    endfunction

    always @(posedge clk) begin
        logic [7:0] ch;
        bit         dz;
        ch = bus.char_data;
        if (rst) begin
            m_tok = 0; m_pend = 0; m_err = 0;
            m_p1 = "0"; m_p2 = "0"; m_sym = "+"; m_cnt = 0;
        end else begin
            m_err = 0;
            if (m_pend) begin
                if (bus.expr_ready) begin
                    m_pend = 0;
                    m_cnt  = m_cnt + 8'd1;
                end
            end else if (bus.char_valid) begin
`ifdef EXPR_COLLECTOR_DIVZERO_CHECK_EN
                dz = (m_sym == "/") && (m_p2 == "0");
`else
                dz = 0;
`endif
                if (ch == "C" || ch == "c") m_tok = 0;
                else if (m_tok == 0) begin
                    if (f_digit(ch)) begin m_p1 = ch; m_tok = 1; end
                    else m_err = 1;
                end else if (m_tok == 1) begin
                    if (f_op(ch)) begin m_sym = ch; m_tok = 2; end
                    else if (f_digit(ch)) m_p1 = ch;
                    else begin m_err = 1; m_tok = 0; end
                end else if (m_tok == 2) begin
                    if (f_digit(ch)) begin m_p2 = ch; m_tok = 3; end
                    else begin m_err = 1; m_tok = 0; end
                end else begin
                    if (ch == "=" && !dz) begin m_pend = 1; m_tok = 0; end
                    else if (f_digit(ch)) m_p2 = ch;
                    else begin m_err = 1; m_tok = 0; end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, once reset has been applied.
    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("char_ready", bus.char_ready, !m_pend);
            chk("expr_valid", bus.expr_valid, m_pend);
            chk("err",        bus.err,        m_err);
            chk("p1",         bus.p1,         m_p1);
            chk("p2",         bus.p2,         m_p2);
            chk("sym",        bus.sym,        m_sym);
            chk("expr_cnt",   bus.expr_cnt,   m_cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] ch);
        bus.char_valid = 1'b1;
        bus.char_data  = ch;
        tick();
        bus.char_valid = 1'b0;
    endtask

    task automatic send4(input logic [7:0] a, b, d, e);
        send(a); send(b); send(d); send(e);
    endtask

    logic [7:0] pool [16];
    initial begin
        pool = '{"0","3","5","9","+","-","*","/","=","=","C","c","x",8'h00,"7","0"};
    end

    initial begin
        bus.char_valid = 1'b0;
        bus.char_data  = 8'h00;
        bus.expr_ready = 1'b1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        cmp_en = 1'b1;

        // reset state
        chk("rst_p1",  bus.p1, 8'h30);
        chk("rst_p2",  bus.p2, 8'h30);
        chk("rst_sym", bus.sym, 8'h2b);
        chk("rst_cnt", bus.expr_cnt, 8'h00);
        chk("rst_rdy", bus.char_ready, 1'b1);
        chk("rst_vld", bus.expr_valid, 1'b0);

        // 7+2=
        send4("7", "+", "2", "=");
        chk("a_vld", bus.expr_valid, 1'b1);
        chk("a_p1",  bus.p1, 8'h37);
        chk("a_sym", bus.sym, 8'h2b);
        chk("a_p2",  bus.p2, 8'h32);
        tick();
        chk("a_vld_drop", bus.expr_valid, 1'b0);
        chk("a_cnt", bus.expr_cnt, 8'h01);

        // 35*4= with operand overwrite
        send("3"); send4("5", "*", "4", "=");
        chk("b_err", bus.err, 1'b0);
        chk("b_p1",  bus.p1, 8'h35);
        chk("b_sym", bus.sym, 8'h2a);
        chk("b_p2",  bus.p2, 8'h34);
        tick();

        // 9= is rejected
        send("9"); send("=");
        chk("c_err", bus.err, 1'b1);
        chk("c_vld", bus.expr_valid, 1'b0);
        tick();
        chk("c_err_one", bus.err, 1'b0);

        // backpressure: 8-1= held while consumer stalls and chars are offered
        bus.expr_ready = 1'b0;
        send4("8", "-", "1", "=");
        bus.char_valid = 1'b1;
        bus.char_data  = "5";
        for (int i = 0; i < 5; i++) begin
            chk("d_vld", bus.expr_valid, 1'b1);
            chk("d_rdy", bus.char_ready, 1'b0);
            chk("d_p1",  bus.p1, 8'h38);
            chk("d_p2",  bus.p2, 8'h31);
            tick();
        end
        bus.char_valid = 1'b0;
        bus.expr_ready = 1'b1;
        tick();
        chk("d_rdy_back", bus.char_ready, 1'b1);
        chk("d_cnt", bus.expr_cnt, 8'h03);

        // divide by zero
        send4("6", "/", "0", "=");
`ifdef EXPR_COLLECTOR_DIVZERO_CHECK_EN
        chk("e_err", bus.err, 1'b1);
        chk("e_vld", bus.expr_valid, 1'b0);
`else
        chk("e_vld", bus.expr_valid, 1'b1);
        chk("e_sym", bus.sym, 8'h2f);
        chk("e_p2",  bus.p2, 8'h30);
`endif
        tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.char_valid = ($urandom_range(0, 3) != 0);
            bus.char_data  = pool[$urandom_range(0, 15)];
            bus.expr_ready = ($urandom_range(0, 2) != 0);
            rst            = ($urandom_range(0, 199) == 0);
            tick();
        end
        bus.char_valid = 1'b0;
        bus.expr_ready = 1'b1;
        rst = 1'b0;
        tick(); tick();

        // 256 back-to-back expressions from a clean counter wrap it to 00
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            send4("1", "+", "1", "=");
            tick();
        end
        chk("f_wrap", bus.expr_cnt, 8'h00);

        // reset mid-expression
        send("4"); send("+");
        chk("g_sym_pre", bus.sym, 8'h2b);
        send("5");
        chk("g_p1_pre", bus.p1, 8'h34);
        bus.char_valid = 1'b1;
        bus.char_data  = "=";
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.char_valid = 1'b0;
        chk("g_p1",  bus.p1, 8'h30);
        chk("g_p2",  bus.p2, 8'h30);
        chk("g_sym", bus.sym, 8'h2b);
        chk("g_vld", bus.expr_valid, 1'b0);
        send("=");
        chk("g_in_d1", bus.err, 1'b1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
